// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter family:
// direction encodings and the load-value clamp helper.
package param_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Clamp arithmetic is done at this fixed width; callers cast in and out.
  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_to_max(
    input logic [CLAMP_W-1:0] val,
    input logic [CLAMP_W-1:0] max_val
  );
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/param_updown_counter_prescaler.sv
// Enable prescaler: produces one step every PRESCALE enabled cycles.
// Holds its phase while en=0; clr_sync (clear or load) restarts it.
module cnt_prescaler #(
  parameter int PRESCALE = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr_sync,
  output logic step
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pre_q;
  logic          at_last;

  assign at_last = (pre_q == LAST);
  assign step    = en & ~clr_sync & at_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q <= '0;
    end else if (clr_sync) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= at_last ? '0 : pre_q + ONE;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised modulo up/down counter with prescaled enable, clear, load and
// registered terminal-count pulse. PARAM_COUNTER_CAPTURE_EN adds cap/cap_val.
module param_updown_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef PARAM_COUNTER_CAPTURE_EN
  input  logic             cap,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             step
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             clr_sync;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic [WIDTH-1:0] load_clamped;

  assign clr_sync     = clr | load;
  assign load_clamped = WIDTH'(clamp_to_max(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL)));

  generate
    if (PRESCALE > 1) begin : g_prescale
      cnt_prescaler #(
        .PRESCALE (PRESCALE)
      ) u_prescaler (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .clr_sync (clr_sync),
        .step     (step)
      );
    end else begin : g_no_prescale
      assign step = en & ~clr_sync;
    end
  endgenerate

  // Priority: clear, then load, then step, else hold. tc only on a wrapping step.
  always_comb begin
    count_d = count;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (step) begin
      case (up_dn)
        DIR_UP: begin
          if (count == MAX_W) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count + ONE;
          end
        end
        DIR_DN: begin
          if (count == '0) begin
            count_d = MAX_W;
            tc_d    = 1'b1;
          end else begin
            count_d = count - ONE;
          end
        end
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_d;
      tc    <= tc_d;
    end
  end

`ifdef PARAM_COUNTER_CAPTURE_EN
  // Captures the pre-update count; independent of clear and load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_val <= '0;
    end else if (cap) begin
      cap_val <= count;
    end
  end
`endif

endmodule
